// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for NUM_DIGITS hex seven-segment digits that share
//   one segment bus. A shadow display word (nibbles + decimal points) is loaded
//   atomically on 'load'. A prescaler gives each digit a slot of exactly CLK_DIV
//   clock cycles. The active digit is decoded 0-F, with optional leading-zero
//   blanking and selectable output polarity. All outputs are registered.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   enable   in   1: scan and drive, 0: all digits off and scan frozen
//   load     in   capture data_in/dp_in into the shadow registers this edge
//   data_in  in   nibble k = hex value of digit k (digit 0 = rightmost)
//   dp_in    in   bit k = decimal point of digit k
//   seg      out  segments {g,f,e,d,c,b,a}
//   dp       out  decimal point of the active digit
//   an       out  digit select, one-hot (one-cold if ACTIVE_LOW) when on
//   slot     out  index of the digit currently driven
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 0,
  parameter int LZ_BLANK   = 1,
  localparam int SLOT_W    = $clog2(NUM_DIGITS),
  localparam int CNT_W     = $clog2(CLK_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SLOT_W-1:0]       slot
);

  // Level that turns a segment / digit off, applied to every output bit.
  localparam logic INV = (ACTIVE_LOW != 0);

  // Scan state and shadow display word
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SLOT_W-1:0]       idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;

  // Registered outputs
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;

  // Active-high segment pattern for a hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; both freeze while enable is low so a
  // re-enable resumes the same digit with its remaining slot time.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) begin
      if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : idx_q + SLOT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Whole word captured in one edge so a digit never shows half-old data.
  always_comb begin
    data_sh_d = load ? data_in : data_sh_q;
    dp_sh_d   = load ? dp_in   : dp_sh_q;
  end

  // blank[k]: digit k and every digit above it have zero value and no dp.
  // Built from the top digit downwards as a running "all zero so far" flag.
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (data_sh_q[4*k +: 4] == 4'h0) && !dp_sh_q[k];
      blank[k] = (LZ_BLANK != 0) && (k != 0) && zero_run;
    end
  end

  // Output next-state: decoded from the current index and shadow word.
  logic [3:0] nib;
  logic       blank_sel;
  always_comb begin
    nib       = data_sh_q[{idx_q, 2'b00} +: 4];
    blank_sel = blank[idx_q];
    seg_d     = '0;
    dp_d      = 1'b0;
    an_d      = '0;
    slot_d    = idx_q;
    if (enable) begin
      // A blanked digit keeps its anode on; only the segments go dark.
      seg_d = blank_sel ? 7'b0000000 : hex_decode(nib);
      dp_d  = !blank_sel && dp_sh_q[idx_q];
      an_d  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    end
    seg_d = seg_d ^ {7{INV}};
    dp_d  = dp_d ^ INV;
    an_d  = an_d ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      data_sh_q <= '0;
      dp_sh_q   <= '0;
      seg_q     <= {7{INV}};
      dp_q      <= INV;
      an_q      <= {NUM_DIGITS{INV}};
      slot_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_sh_q <= data_sh_d;
      dp_sh_q   <= dp_sh_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      slot_q    <= slot_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign slot = slot_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  localparam int ND  = 4;
  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;

  logic [6:0] seg, seg_al;
  logic       dp, dp_al;
  logic [3:0] an, an_al;
  logic [1:0] slot, slot_al;

  seven_segment_scanner #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .ACTIVE_LOW(0), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .slot(slot));

  seven_segment_scanner #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_al (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in), .dp_in(dp_in),
    .seg(seg_al), .dp(dp_al), .an(an_al), .slot(slot_al));

  // ---------------- scoreboard ----------------
  // Expected word = {an[3:0], seg[6:0], dp, slot[1:0]} in active-high form.
  logic [13:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  logic [6:0] dec_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Reference model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;

  // ---------------- driver ----------------
  // Predicts the output for the coming edge, pushes it, clocks, advances the model.
  task automatic step();
    logic [3:0] nib;
    logic       blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (rst) begin
      exp_q.push_back(14'h0);
    end else if (!enable) begin
      exp_q.push_back({4'b0, 7'b0, 1'b0, 2'(m_idx)});
    end else begin
      nib   = m_data[m_idx*4 +: 4];
      blank = (m_idx != 0) && ((m_data >> (4*m_idx)) == 16'h0) && ((m_dp >> m_idx) == 4'h0);
      e_an  = 4'b0001 << m_idx;
      e_seg = blank ? 7'b0 : dec_tab[nib];
      e_dp  = blank ? 1'b0 : m_dp[m_idx];
      exp_q.push_back({e_an, e_seg, e_dp, 2'(m_idx)});
    end
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_data = '0; m_dp = '0;
    end else begin
      if (load) begin
        m_data = data_in;
        m_dp   = dp_in;
      end
      if (enable) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0;
          m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [13:0] e, got, got_al;
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      step();
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      got_al = {~an_al, ~seg_al, ~dp_al, slot_al};
      checks++;
      if (got !== e) $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); else passes++;
      checks++;
      if (got_al !== e) $display("FAIL reset_al[%0d] got=%h exp=%h", i, got_al, e); else passes++;
    end
  endtask

  task automatic test_scan();
    logic [13:0] e, got, got_al;
    data_in = 16'h12AF; dp_in = 4'b0000; load = 1'b1;
    step();
    e = exp_q.pop_front();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      got_al = {~an_al, ~seg_al, ~dp_al, slot_al};
      checks++;
      if (got !== e) $display("FAIL scan[%0d] got=%h exp=%h", i, got, e); else passes++;
      checks++;
      if (got_al !== e) $display("FAIL scan_al[%0d] got=%h exp=%h", i, got_al, e); else passes++;
      if (i == 0) begin
        checks++;
        if ({an, seg} !== {4'b0001, 7'b1110001})
          $display("FAIL scan_first an/seg got=%b/%b exp=0001/1110001", an, seg);
        else passes++;
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [13:0] e, got;
    logic [15:0] d_tab [3] = '{16'h0007, 16'h0000, 16'h0000};
    logic [3:0]  p_tab [3] = '{4'b0000, 4'b0000, 4'b0100};
    for (int p = 0; p < 3; p++) begin
      data_in = d_tab[p]; dp_in = p_tab[p]; load = 1'b1;
      for (int i = 0; i < 18; i++) begin
        step();
        load = 1'b0;
        e = exp_q.pop_front();
        got = {an, seg, dp, slot};
        checks++;
        if (got !== e) $display("FAIL lz_blank[%0d.%0d] got=%h exp=%h", p, i, got, e); else passes++;
      end
    end
  endtask

  task automatic test_active_low();
    logic [13:0] e, got_al;
    data_in = 16'h8888; dp_in = 4'b0000; load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      got_al = {~an_al, ~seg_al, ~dp_al, slot_al};
      checks++;
      if (got_al !== e) $display("FAIL active_low[%0d] got=%h exp=%h", i, got_al, e); else passes++;
      if (i >= 2) begin
        checks++;
        if (seg_al !== 7'b0000000 || $countones(~an_al) != 1)
          $display("FAIL active_low_pins[%0d] seg=%b an=%b exp seg=0000000 one-cold an", i, seg_al, an_al);
        else passes++;
      end
    end
  endtask

  task automatic test_load_advance();
    logic [13:0] e, got;
    int guard;
    guard = 0;
    while (!(m_cnt == DIV - 1 && m_idx == 0) && guard < 40) begin
      step();
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      checks++;
      if (got !== e) $display("FAIL align[%0d] got=%h exp=%h", guard, got, e); else passes++;
      guard++;
    end
    checks++;
    if (guard >= 40) $display("FAIL align_timeout got=%0d exp<40", guard); else passes++;
    data_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    for (int i = 0; i < 14; i++) begin
      // enable drops for 3 cycles in the middle of digit 1's slot
      enable = !(i >= 3 && i < 6);
      step();
      load = 1'b0;
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      checks++;
      if (got !== e) $display("FAIL load_adv[%0d] got=%h exp=%h", i, got, e); else passes++;
      if (i == 1) begin
        checks++;
        if ({an, seg} !== {4'b0010, 7'b1001111})
          $display("FAIL load_adv_digit1 an/seg got=%b/%b exp=0010/1001111", an, seg);
        else passes++;
      end
      if (i == 4) begin
        checks++;
        if (an !== 4'b0000) $display("FAIL enable_off an got=%b exp=0000", an); else passes++;
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [13:0] e, got;
    int guard;
    guard = 0;
    while (!(m_cnt == 1 && m_idx == 2) && guard < 40) begin
      step();
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      checks++;
      if (got !== e) $display("FAIL pre_rst[%0d] got=%h exp=%h", guard, got, e); else passes++;
      guard++;
    end
    checks++;
    if (guard >= 40) $display("FAIL pre_rst_timeout got=%0d exp<40", guard); else passes++;
    rst = 1'b1;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({an, slot, seg} !== {4'b0000, 2'b00, 7'b0}) $display("FAIL rst_mid got=%b/%b/%b exp=0000/00/0000000", an, slot, seg);
    else passes++;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      e = exp_q.pop_front();
      got = {an, seg, dp, slot};
      checks++;
      if (got !== e) $display("FAIL post_rst[%0d] got=%h exp=%h", i, got, e); else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_active_low();
    test_load_advance();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
